fb_reader: RTL

FB_READER -- requirements
Module: fb_reader

---
 rtl/fb_reader_pkg.sv | 6 +
 rtl/fb_fifo.sv | 41 ++++
 rtl/fb_reader.sv | 72 +++++++
 3 files changed

// File: rtl/fb_reader_pkg.sv
// fb_reader_pkg: shared types and widths for the frame-buffer reader
package fb_reader_pkg;
  typedef enum logic {IDLE, FETCH} state_t;
  localparam int PIX_W  = 24;
  localparam int ADDR_W = 32;
endpackage

// File: rtl/fb_fifo.sv
// fb_fifo: synchronous show-ahead FIFO; head entry is visible whenever it is non-empty
module fb_fifo #(
  parameter int W     = 25,
  parameter int DEPTH = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [W-1:0]           data_i,
  input  logic                   pop_i,
  output logic [W-1:0]           data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;
  assign empty_o = count_q == '0;
  assign full_o  = count_q == (AW+1)'(DEPTH);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_q];
  assign count_o = count_q;
  // pointers and occupancy; a push and pop in the same cycle leave the count unchanged
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_q + AW'(do_push);
      rd_q    <= rd_q + AW'(do_pop);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  // storage needs no reset: an entry is only visible after it has been written
  always_ff @(posedge clk_i)
    if (do_push) mem_q[wr_q] <= data_i;
endmodule

// File: rtl/fb_reader.sv
// fb_reader: streams a frame buffer from Avalon-MM SDRAM into a pixel FIFO for the VGA stage
module fb_reader
  import fb_reader_pkg::*;
#(
  parameter int                HDISP      = 800,
  parameter int                VDISP      = 480,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h0,
  parameter int                FIFO_DEPTH = 256
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              enable,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  input  logic              waitrequest,
  input  logic [31:0]       readdata,
  input  logic              readdatavalid,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_sof,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              busy
);
  localparam int NPIX = HDISP * VDISP;
  localparam int IW   = NPIX > 1 ? $clog2(NPIX) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IW-1:0] LAST = IW'(NPIX - 1);
  state_t          state_q;
  logic [IW-1:0]   pix_idx_q, pix_idx_d, ret_idx_q, ret_idx_d;
  logic [CW-1:0]   pending_q, pending_d, fifo_count;
  logic [PIX_W:0]  fifo_out;
  logic            fifo_full, fifo_empty, accept, pop, unused_bits;
  assign busy    = state_q == FETCH;
  assign read    = busy && ({1'b0, pending_q} + {1'b0, fifo_count} < (CW+1)'(FIFO_DEPTH));
  assign address = BASE_ADDR + (ADDR_W'(pix_idx_q) << 2);
  assign accept  = read && !waitrequest;
  assign pop     = pix_valid && pix_ready;
  // request index, return index (source of the sof tag) and outstanding-read count
  always_comb begin
    pix_idx_d = accept ? (pix_idx_q == LAST ? '0 : pix_idx_q + 1'b1) : pix_idx_q;
    ret_idx_d = readdatavalid ? (ret_idx_q == LAST ? '0 : ret_idx_q + 1'b1) : ret_idx_q;
    pending_d = pending_q + CW'(accept) - CW'(readdatavalid);
  end
  // frame FSM and counters; a frame always runs to its last request before going idle
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      pix_idx_q <= '0;
      ret_idx_q <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_q == IDLE ? (enable ? FETCH : IDLE)
                 : (accept && pix_idx_q == LAST && !enable ? IDLE : FETCH);
      pix_idx_q <= pix_idx_d;
      ret_idx_q <= ret_idx_d;
      pending_q <= pending_d;
    end
  fb_fifo #(.W(PIX_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (sys_clk),
    .rst_ni  (sys_rst_n),
    .push_i  (readdatavalid),
    .data_i  ({ret_idx_q == '0, readdata[PIX_W-1:0]}),
    .pop_i   (pop),
    .data_o  (fifo_out),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );
  assign pix_valid          = !fifo_empty;
  assign {pix_sof, pix_data} = fifo_out;
  assign unused_bits        = ^{readdata[31:PIX_W], fifo_full};
endmodule
